// File: rtl/mult_seq_huit_if.sv
// Operand/result handshake bundle for mult_seq_huit.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low, and ready never depends on valid.
interface mult_seq_huit_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    // master: operand producer and result consumer
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    // slave: the multiplier itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mult_seq_huit.sv
// Sequential 8x8->16 unsigned shift-and-add multiplier.
// add_seize is the 16-bit ripple-carry adder used as the datapath adder;
// mult_seq_huit sequences eight add/shift steps through it per operation.

// 16-bit ripple-carry adder with carry in and carry out.
module add_seize (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        rin,
    output logic [15:0] sum,
    output logic        rout
);
    logic [16:0] carry;

    assign carry[0] = rin;

    // one full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign rout = carry[16];
endmodule

// Multiplier top: accepts a/b in IDLE, runs eight steps in RUN, holds the
// product in DONE until the consumer takes it.
module mult_seq_huit (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_huit_if.slave  bus,
    output logic [1:0]      state_dbg,   // current FSM state encoding
    output logic            rout_dbg     // adder carry out, must stay 0
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    logic [15:0] acc;

    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_rout;

    // Partial-product term: the shifted multiplicand when the current
    // multiplier bit is set, otherwise nothing to add this step.
    assign add_b = mplier[0] ? mcand : 16'h0000;

    add_seize u_add (
        .a    (acc),
        .b    (add_b),
        .rin  (1'b0),
        .sum  (add_sum),
        .rout (add_rout)
    );

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; outputs depend on state only, so
    // there is no combinational path from inputs to in_ready/out_valid.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // all eight steps always run, no early exit on mplier == 0
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, add/shift each RUN step, freeze otherwise.
    // acc is not cleared on leaving DONE so p keeps the last product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            cnt    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= {8'h00, bus.a};
                        mplier <= bus.b;
                        acc    <= 16'h0000;
                        cnt    <= 3'd0;
                    end
                end
                RUN: begin
                    acc    <= add_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                end
                default: begin
                    acc    <= acc;
                end
            endcase
        end
    end

    assign bus.p     = acc;
    assign state_dbg = state;
    assign rout_dbg  = add_rout;
endmodule
